xbar_allocator: RTL and testbench
=================================

XBAR_ALLOCATOR -- requirements
Module: xbar_allocator

Interface
REQ-001 Parameter CREDITS, default 4, meaning downstream buffer slots per output port (range 1..15).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  5  per input port i (0=L,1=N,2=E,3=W,4=S): flit present.
REQ-005 in_dest  input  15  3 bits per input (bits 3i+2:3i): requested output port 0..4; values 5..7 are illegal.
REQ-006 in_tail  input  5  per input: flit is last of packet (single-flit packet = header with tail set).
REQ-007 credit_ret  input  5  per output: one downstream slot freed this cycle.
REQ-008 grant  output  5  per input: flit accepted this cycle (combinational).
REQ-009 out_valid  output  5  per output: flit forwarded this cycle (combinational).
REQ-010 out_sel  output  15  3 bits per output: index of the input driving that output; 0 when out_valid low.
REQ-011 credit_err  output  1  sticky: credit_ret seen while that output's counter is at CREDITS.

Function
REQ-012 Each output o SHALL hold an independent FSM with states IDLE and LOCKED(owner), a 3-bit round-robin pointer rr[o], and a 4-bit credit counter cr[o].
REQ-013 Input i requests o when in_valid[i]=1 and in_dest[i]=o; an illegal dest SHALL never be granted and SHALL not change state.
REQ-014 IDLE: the winner SHALL be the first requesting input found scanning rr[o], rr[o]+1, ... modulo 5; the grant is issued only if cr[o]>0.
REQ-015 IDLE grant: out_valid[o]=1, out_sel[o]=winner, grant[winner]=1, rr[o] <= (winner+1) mod 5; if in_tail[winner]=0, state <= LOCKED(winner), else stays IDLE.
REQ-016 LOCKED(k): only input k SHALL be considered; grant when in_valid[k]=1, in_dest[k]=o and cr[o]>0; other requesters get no grant.
REQ-017 LOCKED(k): a granted flit with in_tail[k]=1 SHALL return the FSM to IDLE next cycle; rr[o] unchanged in LOCKED.
REQ-018 LOCKED(k) with in_dest[k]!=o or in_valid[k]=0: no grant, state held (no timeout).
REQ-019 An input SHALL receive at most one grant per cycle; since it names one dest, grant[i] is the OR over outputs.
REQ-020 cr[o] next = cr[o] - out_valid[o] + credit_ret[o]; simultaneous forward and return leaves cr[o] unchanged.
REQ-021 credit_ret[o] with cr[o]=CREDITS and no forward: counter stays CREDITS, credit_err <= 1.
REQ-022 cr[o]=0: no grant to o regardless of state; a credit_ret in that cycle enables grant only from the next cycle.
REQ-023 Grant decisions SHALL use current-cycle registered state only (zero-cycle request-to-grant latency); state updates visible next cycle.

Reset
REQ-024 rst=1 at a clock edge SHALL set all FSMs IDLE, rr[o]=0, cr[o]=CREDITS, credit_err=0, overriding all other inputs including mid-packet locks.
REQ-025 While rst=1, grant and out_valid SHALL be 0 and out_sel 0.

Verification
REQ-026 Reset, then inputs 0,1,2 all request output 3 with tail=1 for 3 cycles -> grants to 0, then 1, then 2; rr[3] ends at 3.
REQ-027 Input 1 sends header (tail=0) to output 2, input 4 also requests 2 -> input 1 holds output 2 for header, 2 body, tail; input 4 granted the cycle after tail.
REQ-028 CREDITS=4, no credit_ret, input 0 streams to output 0 with tail=1 -> exactly 4 grants, then grant stalls; one credit_ret -> one more grant next cycle.
REQ-029 cr=CREDITS and credit_ret[1]=1 with no traffic -> credit_err=1 and stays 1 until rst.
REQ-030 rst asserted while output 4 LOCKED to input 2 -> next cycle output 4 IDLE, cr[4]=CREDITS, input 3 requesting 4 granted immediately.
REQ-031 Inputs 0 and 2 request outputs 1 and 3 respectively in the same cycle -> both granted concurrently, out_sel[1]=0, out_sel[3]=2.

Source files
------------

// File: rtl/xbar_allocator.sv
// Five-port wormhole crossbar allocator: per-output round-robin arbitration, packet locking, and credit tracking.
// Grants are combinational from registered state, so there is zero request-to-grant latency; an output with no credit grants nothing.
module xbar_allocator #(
  parameter int CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_valid,
  input  logic [14:0] in_dest,
  input  logic [4:0]  in_tail,
  input  logic [4:0]  credit_ret,
  output logic [4:0]  grant,
  output logic [4:0]  out_valid,
  output logic [14:0] out_sel,
  output logic        credit_err
);

  localparam logic       ST_IDLE   = 1'b0;
  localparam logic       ST_LOCKED = 1'b1;
  localparam logic [3:0] CR_MAX    = 4'(CREDITS);

  logic [4:0] gmask [5];
  logic [4:0] err_set;

  for (genvar o = 0; o < 5; o++) begin : g_out
    logic       state;
    logic [2:0] owner;
    logic [2:0] rr;
    logic [3:0] cr;
    logic [4:0] req;
    logic [2:0] win;
    logic       hit;
    logic       fire;

    always_comb begin
      for (int i = 0; i < 5; i++) begin
        req[i] = in_valid[i] && (in_dest[3*i +: 3] == 3'(o));
      end
    end

    // A locked output only listens to its owner; otherwise scan from rr with wrap at 5.
    always_comb begin
      logic [3:0] sum;
      logic [2:0] idx;
      hit = 1'b0;
      win = 3'd0;
      sum = 4'd0;
      idx = 3'd0;
      if (state == ST_LOCKED) begin
        hit = req[owner];
        win = owner;
      end else begin
        for (int k = 0; k < 5; k++) begin
          sum = {1'b0, rr} + 4'(k);
          idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
          if (!hit && req[idx]) begin
            hit = 1'b1;
            win = idx;
          end
        end
      end
    end

    assign fire               = hit && (cr != 4'd0) && !rst;
    assign out_valid[o]       = fire;
    assign out_sel[3*o +: 3]  = fire ? win : 3'd0;
    assign gmask[o]           = fire ? (5'b00001 << win) : 5'b00000;
    assign err_set[o]         = credit_ret[o] && !fire && (cr == CR_MAX);

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_IDLE;
        owner <= 3'd0;
        rr    <= 3'd0;
        cr    <= CR_MAX;
      end else begin
        if (fire) begin
          if (state == ST_IDLE) begin
            rr <= (win == 3'd4) ? 3'd0 : win + 3'd1;
            if (!in_tail[win]) begin
              state <= ST_LOCKED;
              owner <= win;
            end
          end else if (in_tail[win]) begin
            state <= ST_IDLE;
          end
        end
        // A return while already full is dropped and flagged through err_set.
        case ({fire, credit_ret[o]})
          2'b10:   cr <= cr - 4'd1;
          2'b01:   if (cr != CR_MAX) cr <= cr + 4'd1;
          default: cr <= cr;
        endcase
      end
    end
  end

  always_comb begin
    grant = 5'b00000;
    for (int o = 0; o < 5; o++) begin
      grant = grant | gmask[o];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_err <= 1'b0;
    end else if (|err_set) begin
      credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xbar_allocator.sv
// Table-driven bench for xbar_allocator: each record is driven, its expectation queued, then popped and checked mid-cycle.
module tb_xbar_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_valid;
  logic [14:0] in_dest;
  logic [4:0]  in_tail;
  logic [4:0]  credit_ret;
  logic [4:0]  grant;
  logic [4:0]  out_valid;
  logic [14:0] out_sel;
  logic        credit_err;

  xbar_allocator #(.CREDITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dest(in_dest),
    .in_tail(in_tail), .credit_ret(credit_ret), .grant(grant),
    .out_valid(out_valid), .out_sel(out_sel), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  valid;
    logic [14:0] dest;
    logic [4:0]  tail;
    logic [4:0]  ret;
    logic [4:0]  exp_grant;
    logic [4:0]  exp_ov;
    logic [14:0] exp_sel;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [14:0] dst(input int a, input int b, input int c, input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [4:0] v, input logic [14:0] d,
                              input logic [4:0] t, input logic [4:0] cr, input logic [4:0] g,
                              input logic [4:0] ov, input logic [14:0] s, input logic e);
    vec_t x;
    x.rst = r; x.valid = v; x.dest = d; x.tail = t; x.ret = cr;
    x.exp_grant = g; x.exp_ov = ov; x.exp_sel = s; x.exp_err = e;
    return x;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [14:0] act, input logic [14:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    rst = v.rst; in_valid = v.valid; in_dest = v.dest; in_tail = v.tail; credit_ret = v.ret;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard step %0d: queue empty", idx);
    end else begin
      e = exp_q.pop_front();
      cmp("grant", idx, 15'(grant), 15'(e.exp_grant));
      cmp("out_valid", idx, 15'(out_valid), 15'(e.exp_ov));
      cmp("out_sel", idx, out_sel, e.exp_sel);
      cmp("credit_err", idx, 15'(credit_err), 15'(e.exp_err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_dest = '0; in_tail = '0; credit_ret = '0;

    // Reset gating and round-robin on output 3, then credit exhaustion.
    tbl.push_back(mk(1, 5'b11111, dst(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0));
    tbl.push_back(mk(1, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00111, dst(3,3,3,0,0), 5'b11111, 5'b00000, 5'b00001, 5'b01000, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00111, dst(3,3,3,0,0), 5'b11111, 5'b00000, 5'b00010, 5'b01000, 15'h0200, 0));
    tbl.push_back(mk(0, 5'b00111, dst(3,3,3,0,0), 5'b11111, 5'b00000, 5'b00100, 5'b01000, 15'h0400, 0));
    tbl.push_back(mk(0, 5'b00111, dst(3,3,3,0,0), 5'b11111, 5'b00000, 5'b00001, 5'b01000, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00111, dst(3,3,3,0,0), 5'b11111, 5'b01000, 5'b00000, 5'b00000, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00111, dst(3,3,3,0,0), 5'b11111, 5'b00000, 5'b00010, 5'b01000, 15'h0200, 0));
    // Concurrent grants to different outputs, then illegal destinations.
    tbl.push_back(mk(1, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00101, dst(1,0,3,0,0), 5'b11111, 5'b00000, 5'b00101, 5'b01010, 15'h0400, 0));
    tbl.push_back(mk(0, 5'b00011, dst(5,7,0,0,0), 5'b11111, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0));
    // Packet lock on output 2 by input 1 while input 4 waits.
    tbl.push_back(mk(0, 5'b10010, dst(0,2,0,0,2), 5'b10000, 5'b00000, 5'b00010, 5'b00100, 15'h0040, 0));
    tbl.push_back(mk(0, 5'b10010, dst(0,2,0,0,2), 5'b10000, 5'b00000, 5'b00010, 5'b00100, 15'h0040, 0));
    tbl.push_back(mk(0, 5'b10010, dst(0,0,0,0,2), 5'b10010, 5'b00000, 5'b00010, 5'b00001, 15'h0001, 0));
    tbl.push_back(mk(0, 5'b10010, dst(0,2,0,0,2), 5'b10000, 5'b00100, 5'b00010, 5'b00100, 15'h0040, 0));
    tbl.push_back(mk(0, 5'b10010, dst(0,2,0,0,2), 5'b10010, 5'b00000, 5'b00010, 5'b00100, 15'h0040, 0));
    tbl.push_back(mk(0, 5'b10000, dst(0,0,0,0,2), 5'b10000, 5'b00000, 5'b10000, 5'b00100, 15'h0100, 0));
    // Credit overflow on a full output, sticky until reset.
    tbl.push_back(mk(0, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b10000, 5'b00000, 5'b00000, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 1));
    tbl.push_back(mk(1, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 1));
    // Input 0 streams single-flit packets to output 0 until credits run dry.
    for (int n = 0; n < 4; n++)
      tbl.push_back(mk(0, 5'b00001, dst(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00001, 5'b00001, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00001, dst(0,0,0,0,0), 5'b11111, 5'b00001, 5'b00000, 5'b00000, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00001, dst(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00001, 5'b00001, 15'h0000, 0));
    tbl.push_back(mk(0, 5'b00001, dst(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Reset breaks a mid-packet lock on output 4 and refills its credits.
    step(mk(1, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0), 100);
    step(mk(0, 5'b00100, dst(0,0,4,0,0), 5'b00000, 5'b00000, 5'b00100, 5'b10000, 15'h2000, 0), 101);
    step(mk(0, 5'b01000, dst(0,0,0,4,0), 5'b01000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0), 102);
    step(mk(1, 5'b01000, dst(0,0,0,4,0), 5'b01000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0), 103);
    for (int n = 0; n < 4; n++)
      step(mk(0, 5'b01000, dst(0,0,0,4,0), 5'b01000, 5'b00000, 5'b01000, 5'b10000, 15'h3000, 0), 104 + n);
    step(mk(0, 5'b01000, dst(0,0,0,4,0), 5'b01000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0), 108);

    // Spurious credit return on idle output 1.
    step(mk(1, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 0), 110);
    step(mk(0, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00010, 5'b00000, 5'b00000, 15'h0000, 0), 111);
    step(mk(0, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 1), 112);
    step(mk(0, 5'b00000, dst(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 1), 113);
    step(mk(0, 5'b00001, dst(1,0,0,0,0), 5'b00001, 5'b00000, 5'b00001, 5'b00010, 15'h0000, 1), 114);

    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
